// File: rtl/gs_ctrl_axil_slave_pkg.sv
// Shared types and constants for the grayscale-core AXI4-Lite control slave.
package gs_ctrl_pkg;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    localparam int GS_REG_CTRL = 0;
    localparam int GS_REG_1    = 1;
    localparam int GS_REG_2    = 2;
    localparam int GS_REG_3    = 3;
    localparam int GS_NUM_REGS = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/gs_ctrl_axil_slave_if.sv
// AXI4-Lite bus bundle for the grayscale control slave, with master/slave views.
interface gs_ctrl_axil_slave_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/gs_ctrl_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit config registers and a start pulse.
// Define GS_AXIL_ADDR_DECERR_EN to answer unmapped accesses with SLVERR.
module gs_ctrl_axil_slave
    import gs_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    gs_ctrl_axil_slave_if.slave           s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg3,
    output logic                          start_pulse
);

    localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

`ifdef GS_AXIL_ADDR_DECERR_EN
    localparam logic [1:0] UNMAPPED_RESP = AXI_RESP_SLVERR;
`else
    localparam logic [1:0] UNMAPPED_RESP = AXI_RESP_OKAY;
`endif

    w_state_t w_state;
    r_state_t r_state;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [GS_NUM_REGS];
    logic                          aw_done;
    logic                          w_done;
    logic [IDX_W-1:0]              aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
    logic [NUM_BYTES-1:0]          w_strb;

    logic                          aw_hs, w_hs, ar_hs, wr_fire;
    logic [IDX_W-1:0]              wr_idx, rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]          wr_strb;
    logic                          wr_mapped, rd_mapped;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        aw_hs     = s_axi.awvalid & s_axi.awready;
        w_hs      = s_axi.wvalid & s_axi.wready;
        ar_hs     = s_axi.arvalid & s_axi.arready;
        wr_idx    = aw_hs ? s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx;
        wr_data   = w_hs ? s_axi.wdata : w_data;
        wr_strb   = w_hs ? s_axi.wstrb : w_strb;
        wr_fire   = (w_state == W_IDLE) & (aw_done | aw_hs) & (w_done | w_hs);
        rd_idx    = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
        wr_mapped = wr_idx < IDX_W'(GS_NUM_REGS);
        rd_mapped = rd_idx < IDX_W'(GS_NUM_REGS);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_IDLE;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= AXI_RESP_OKAY;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            start_pulse   <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (wr_fire) begin
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b0;
                        s_axi.bvalid  <= 1'b1;
                        s_axi.bresp   <= wr_mapped ? AXI_RESP_OKAY : UNMAPPED_RESP;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        start_pulse   <= (wr_idx == IDX_W'(GS_REG_CTRL)) & wr_strb[0] & wr_data[0];
                        w_state       <= W_RESP;
                    end else begin
                        // Each channel closes independently once its beat is held.
                        if (aw_hs) begin
                            aw_done <= 1'b1;
                            aw_idx  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                        end
                        if (w_hs) begin
                            w_done <= 1'b1;
                            w_data <= s_axi.wdata;
                            w_strb <= s_axi.wstrb;
                        end
                        s_axi.awready <= ~(aw_done | aw_hs);
                        s_axi.wready  <= ~(w_done | w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid  <= 1'b0;
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the register file is reset because its contents drive the core directly.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < GS_NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_fire && wr_mapped) begin
            for (int b = 0; b < NUM_BYTES; b++)
                if (wr_strb[b]) regs[wr_idx[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_IDLE;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= AXI_RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        // Sampled before any same-edge write lands, so reads see the old value.
                        s_axi.rdata   <= rd_mapped ? regs[rd_idx[1:0]] : '0;
                        s_axi.rresp   <= rd_mapped ? AXI_RESP_OKAY : UNMAPPED_RESP;
                        s_axi.rvalid  <= 1'b1;
                        s_axi.arready <= 1'b0;
                        r_state       <= R_RESP;
                    end else begin
                        s_axi.arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        s_axi.rvalid  <= 1'b0;
                        s_axi.arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign cfg_reg0 = regs[GS_REG_CTRL];
    assign cfg_reg1 = regs[GS_REG_1];
    assign cfg_reg2 = regs[GS_REG_2];
    assign cfg_reg3 = regs[GS_REG_3];

    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_gs_ctrl_axil_slave.sv
// Scoreboard bench for gs_ctrl_axil_slave: drivers queue expected B/R responses, a monitor checks them.
module tb_gs_ctrl_axil_slave;
    import gs_ctrl_pkg::*;

`ifdef GS_AXIL_ADDR_DECERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg0, cfg1, cfg2, cfg3;
    logic        start_pulse;

    always #5 clk = ~clk;

    gs_ctrl_axil_slave_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    gs_ctrl_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus.slave),
        .cfg_reg0     (cfg0),
        .cfg_reg1     (cfg1),
        .cfg_reg2     (cfg2),
        .cfg_reg3     (cfg3),
        .start_pulse  (start_pulse)
    );

    int          checks = 0;
    int          failures = 0;
    int          pulse_cnt = 0;
    logic        prev_bvalid = 1'b0;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [1:0]  exp_b;
    logic [33:0] exp_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed B/R handshake against the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bvalid && bus.bready) begin
                if (bq.size() == 0) check("b_unexpected", 32'(bq.size()), 1);
                else begin
                    exp_b = bq.pop_front();
                    check("bresp", 32'(bus.bresp), 32'(exp_b));
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) check("r_unexpected", 32'(rq.size()), 1);
                else begin
                    exp_r = rq.pop_front();
                    check("rdata", bus.rdata, exp_r[33:2]);
                    check("rresp", 32'(bus.rresp), 32'(exp_r[1:0]));
                end
            end
            if (start_pulse) begin
                pulse_cnt++;
                check("pulse_on_brise", 32'({prev_bvalid, bus.bvalid}), 32'b01);
            end
        end
        prev_bvalid = bus.bvalid;
    end

    task automatic hs_aw(input logic [5:0] a);
        bit ok = 0;
        bus.awaddr = a; bus.awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); if (bus.awready) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.awvalid = 1'b0;
        check("aw_timeout", 32'(ok), 1);
    endtask

    task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); if (bus.wready) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.wvalid = 1'b0;
        check("w_timeout", 32'(ok), 1);
    endtask

    task automatic hs_ar(input logic [5:0] a);
        bit ok = 0;
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); if (bus.arready) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.arvalid = 1'b0;
        check("ar_timeout", 32'(ok), 1);
    endtask

    task automatic wait_b();
        bit ok = 0;
        bus.bready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); if (bus.bvalid) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.bready = 1'b0;
        check("b_timeout", 32'(ok), 1);
    endtask

    task automatic wait_r();
        bit ok = 0;
        bus.rready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); if (bus.rvalid) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.rready = 1'b0;
        check("r_timeout", 32'(ok), 1);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp);
        bq.push_back(resp);
        fork
            hs_aw(a);
            hs_w(d, s);
        join
        wait_b();
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp);
        rq.push_back({d, resp});
        hs_ar(a);
        wait_r();
    endtask

    // One channel first, a gap, then the other; BVALID must appear right after the later beat.
    task automatic write_split(input logic [5:0] a, input logic [31:0] d, input bit w_first,
                               input int gap);
        bq.push_back(AXI_RESP_OKAY);
        if (w_first) hs_w(d, 4'hF); else hs_aw(a);
        repeat (gap) begin
            @(negedge clk); check("no_early_b", 32'(bus.bvalid), 0);
            @(posedge clk); #1;
        end
        if (w_first) hs_aw(a); else hs_w(d, 4'hF);
        @(negedge clk); check("b_rise_next", 32'(bus.bvalid), 1);
        @(posedge clk); #1;
        wait_b();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_cfg0", cfg0, 0);
        check("rst_start", 32'(start_pulse), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("ready_after_rst", 32'({bus.awready, bus.wready, bus.arready}), 32'b111);
        @(posedge clk); #1;

        // Basic write / read-back of all four registers.
        axi_write(6'h00, 32'h1, 4'hF, AXI_RESP_OKAY);
        axi_write(6'h04, 32'h2, 4'hF, AXI_RESP_OKAY);
        axi_write(6'h08, 32'h3, 4'hF, AXI_RESP_OKAY);
        axi_write(6'h0C, 32'h4, 4'hF, AXI_RESP_OKAY);
        axi_read(6'h00, 32'h1, AXI_RESP_OKAY);
        axi_read(6'h04, 32'h2, AXI_RESP_OKAY);
        axi_read(6'h08, 32'h3, AXI_RESP_OKAY);
        axi_read(6'h0C, 32'h4, AXI_RESP_OKAY);
        check("pulse_count_basic", 32'(pulse_cnt), 1);

        // Channel ordering.
        write_split(6'h08, 32'hCAFEF00D, 1'b1, 3);
        check("cfg2_wfirst", cfg2, 32'hCAFEF00D);
        write_split(6'h0C, 32'h12345678, 1'b0, 3);
        check("cfg3_awfirst", cfg3, 32'h12345678);

        // Byte strobes, and an empty strobe that still answers.
        axi_write(6'h04, 32'h11111111, 4'hF, AXI_RESP_OKAY);
        axi_write(6'h04, 32'hAABBCCDD, 4'b0101, AXI_RESP_OKAY);
        check("cfg1_strb", cfg1, 32'h11BB11DD);
        axi_write(6'h04, 32'hFFFFFFFF, 4'h0, AXI_RESP_OKAY);
        check("cfg1_strb0", cfg1, 32'h11BB11DD);

        // Back-pressure on B then R.
        bq.push_back(AXI_RESP_OKAY);
        fork
            hs_aw(6'h08);
            hs_w(32'hDEADBEEF, 4'hF);
        join
        repeat (5) begin
            @(negedge clk);
            check("bstall_bvalid", 32'(bus.bvalid), 1);
            check("bstall_bresp", 32'(bus.bresp), 0);
            check("bstall_readies", 32'({bus.awready, bus.wready}), 0);
            @(posedge clk); #1;
        end
        wait_b();
        rq.push_back({32'hDEADBEEF, AXI_RESP_OKAY});
        hs_ar(6'h08);
        repeat (5) begin
            @(negedge clk);
            check("rstall_rvalid", 32'(bus.rvalid), 1);
            check("rstall_rdata", bus.rdata, 32'hDEADBEEF);
            check("rstall_arready", 32'(bus.arready), 0);
            @(posedge clk); #1;
        end
        wait_r();

        // Unmapped space.
        axi_read(6'h20, 32'h0, UNMAP_RESP);
        axi_write(6'h24, 32'h55555555, 4'hF, UNMAP_RESP);
        check("unmap_cfg0", cfg0, 32'h1);
        check("unmap_cfg1", cfg1, 32'h11BB11DD);
        check("unmap_cfg2", cfg2, 32'hDEADBEEF);
        check("unmap_cfg3", cfg3, 32'h12345678);

        // Same-edge read and write to one word returns the old value.
        fork
            axi_write(6'h0C, 32'h0BADCAFE, 4'hF, AXI_RESP_OKAY);
            axi_read(6'h0C, 32'h12345678, AXI_RESP_OKAY);
        join
        axi_read(6'h0C, 32'h0BADCAFE, AXI_RESP_OKAY);
        check("pulse_count_final", 32'(pulse_cnt), 1);

        // Reset while a response is pending.
        fork
            hs_aw(6'h04);
            hs_w(32'h77, 4'hF);
        join
        @(negedge clk); check("pre_rst_bvalid", 32'(bus.bvalid), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_bvalid", 32'(bus.bvalid), 0);
        check("midrst_cfg", cfg0 | cfg1 | cfg2 | cfg3, 0);
        check("midrst_awready", 32'(bus.awready), 0);
        bq.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("post_rst_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'b111);
        @(posedge clk); #1;
        axi_write(6'h08, 32'h00000ABC, 4'hF, AXI_RESP_OKAY);
        check("post_rst_cfg2", cfg2, 32'h00000ABC);
        check("post_rst_cfg1", cfg1, 32'h0);
        axi_read(6'h08, 32'h00000ABC, AXI_RESP_OKAY);

        repeat (2) @(posedge clk);
        check("bq_drained", 32'(bq.size()), 0);
        check("rq_drained", 32'(rq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gs_ctrl_axil_slave.md
GS_CTRL_AXIL_SLAVE -- requirements
Module: gs_ctrl_axil_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width; 16 word slots.
REQ-003 S_AXI_ACLK  in  1  sole clock; all logic is on its rising edge.
REQ-004 S_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address channel.
REQ-006 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write data channel.
REQ-007 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write response channel.
REQ-008 S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read address channel.
REQ-009 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read data channel.
REQ-010 cfg_reg0..cfg_reg3  out  32 each  current register contents, driven to the grayscale core.
REQ-011 start_pulse  out  1  one-cycle pulse on every committed write to word 0 with WSTRB[0]=1 and WDATA[0]=1.

Function
REQ-012 Register map: word index = ADDR[ADDR_W-1:2]; words 0..3 = cfg_reg0..3, read/write; words 4..15 unmapped; ADDR[1:0] ignored.
REQ-013 Write FSM states: W_IDLE, W_RESP.
REQ-014 W_IDLE: AWREADY=1 until AW captured; WREADY=1 until W captured; AW and W are accepted independently, in either order or in the same cycle.
REQ-015 On the edge where the second of AW/W completes, the SHALL-write commits (byte lanes per WSTRB), BVALID=1, and the FSM enters W_RESP; BVALID therefore rises one cycle after the last handshake.
REQ-016 W_RESP: AWREADY=WREADY=0; BVALID held with BRESP stable until BREADY=1, then W_IDLE next cycle.
REQ-017 At most one write outstanding; WSTRB=0 commits nothing but still returns a response.
REQ-018 Read FSM states: R_IDLE (ARREADY=1), R_RESP (ARREADY=0, RVALID=1).
REQ-019 On the AR handshake, RDATA/RRESP are registered and RVALID rises next cycle; RDATA and RRESP are held stable until RREADY=1.
REQ-020 Read and write commit on the same edge to the same word: the read returns the pre-write value.
REQ-021 Unmapped read returns RDATA=0; unmapped write changes no register.
REQ-022 start_pulse is asserted in the cycle BVALID rises, for exactly one cycle.

Reset
REQ-023 While S_AXI_ARESET=1: cfg_reg0..3=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, start_pulse=0, both FSMs in IDLE, captured AW/W cleared.
REQ-024 Reset mid-transaction discards the transaction without a response; READY signals rise the first cycle after reset deasserts.

Configuration
REQ-025 Macro GS_AXIL_ADDR_DECERR_EN defined: unmapped accesses return BRESP/RRESP=2'b10 (SLVERR).
REQ-026 Macro GS_AXIL_ADDR_DECERR_EN undefined: all responses are OKAY (2'b00); the behaviour in REQ-021 is unchanged.

Structure
REQ-027 Package gs_ctrl_pkg holds the FSM state enums, the word-index localparams (GS_REG_CTRL=0 .. GS_REG_3=3, GS_NUM_REGS=4), and the AXI response codes.
REQ-028 A single flat module; no sub-module.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC and read them back -> reads return 0x1..0x4 with RRESP=OKAY; start_pulse fires once, on the write to 0x0.
REQ-030 W presented 3 cycles before AW, then AW before W -> each write commits once and BVALID rises one cycle after the later handshake.
REQ-031 Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over 0x11111111 -> cfg_reg1=0x11BB11DD.
REQ-032 BREADY/RREADY held low for 5 cycles -> BVALID/RVALID and data stay stable; no new AW/W/AR accepted.
REQ-033 Read 0x20 -> RDATA=0; RRESP=SLVERR with the macro, OKAY without it.
REQ-034 Assert reset while BVALID=1 -> BVALID=0 and all cfg_reg=0 on the next edge; a subsequent write completes normally.
